uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx serializer between N_REQ byte requesters on tx_clk.

---
 rtl/uart_tx_arbiter_pkg.sv | 16 +
 rtl/uart_tx_arbiter_rr.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the uart_tx byte arbiter and its round-robin picker.
package uart_tx_arbiter_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_GAP       = 3'd4
   } arb_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] winner,
   output logic [IDX_W-1:0] winner_idx,
   output logic             any_valid
);

   int   cand;
   logic found;

   always_comb begin
      winner     = '0;
      winner_idx = '0;
      found      = 1'b0;
      cand       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!found && valid[IDX_W'(cand)]) begin
            found                     = 1'b1;
            winner[IDX_W'(cand)]      = 1'b1;
            winner_idx                = IDX_W'(cand);
         end
      end
   end

   assign any_valid = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between N_REQ byte requesters: round-robin pick,
// one-cycle start strobe, busy tracking with timeout, then an idle gap.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int DATA_W       = 8,
   parameter int GAP_CYCLES   = 2,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                      tx_clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          grant,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_start,
   input  logic                      tx_busy,
   output logic                      timeout_err,
   output logic                      active
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(max_int(BUSY_TIMEOUT, GAP_CYCLES) + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   arb_state_e        state;
   logic [IDX_W-1:0]  ptr;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic [N_REQ-1:0]  win_onehot;
   logic [IDX_W-1:0]  win_idx;
   logic [IDX_W-1:0]  next_ptr;
   logic              any_valid;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .valid      (req_valid),
      .ptr        (ptr),
      .winner     (win_onehot),
      .winner_idx (win_idx),
      .any_valid  (any_valid)
   );

   // Ready is only offered while idle and out of reset, so a held byte is never lost.
   assign req_ready = (state == S_IDLE && !rst) ? win_onehot : '0;
   assign active    = (state != S_IDLE);
   assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   assign next_ptr  = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

   always_ff @(posedge tx_clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         ptr         <= '0;
         cnt         <= '0;
         grant       <= '0;
         tx_data     <= '0;
         tx_start    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         tx_start    <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_valid) begin
                  tx_data  <= req_data[int'(win_idx)*DATA_W +: DATA_W];
                  grant    <= win_onehot;
                  ptr      <= next_ptr;
                  cnt      <= '0;
                  tx_start <= 1'b1;
                  state    <= S_START;
               end
            end
            S_START: begin
               cnt   <= cnt_inc;
               state <= S_WAIT_BUSY;
            end
            // The timeout counter runs from the start strobe, so the pulse lands BUSY_TIMEOUT cycles after it.
            S_WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= S_WAIT_DONE;
               end else if (cnt >= TO_LAST) begin
                  timeout_err <= 1'b1;
                  cnt         <= '0;
                  if (GAP_CYCLES > 0) begin
                     state <= S_GAP;
                  end else begin
                     state <= S_IDLE;
                     grant <= '0;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_WAIT_DONE: begin
               if (!tx_busy) begin
                  cnt <= '0;
                  if (GAP_CYCLES > 0) begin
                     state <= S_GAP;
                  end else begin
                     state <= S_IDLE;
                     grant <= '0;
                  end
               end
            end
            S_GAP: begin
               if (cnt >= GAP_LAST) begin
                  state <= S_IDLE;
                  grant <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= S_IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scenario bench for uart_tx_arbiter: a GAP_CYCLES=2 instance and a GAP_CYCLES=0 instance.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int GAP = 2;
   localparam int BT  = 16;

   logic            tx_clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic            tx_busy = 1'b0;
   logic [N-1:0]    req_ready, grant;
   logic [DW-1:0]   tx_data;
   logic            tx_start, timeout_err, active;

   logic [N-1:0]    z_valid = '0;
   logic [N*DW-1:0] z_data = '0;
   logic            z_busy = 1'b0;
   logic [N-1:0]    z_ready, z_grant;
   logic [DW-1:0]   z_tx_data;
   logic            z_start, z_err, z_active;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int model_ptr = 0;

   always #5 tx_clk = ~tx_clk;

   uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BT)) dut (
      .tx_clk(tx_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .grant(grant), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .timeout_err(timeout_err), .active(active));

   uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .GAP_CYCLES(0), .BUSY_TIMEOUT(BT)) dut_z (
      .tx_clk(tx_clk), .rst(rst), .req_valid(z_valid), .req_data(z_data),
      .req_ready(z_ready), .grant(z_grant), .tx_data(z_tx_data), .tx_start(z_start),
      .tx_busy(z_busy), .timeout_err(z_err), .active(z_active));

   task automatic tick();
      @(posedge tx_clk);
      #1;
      cyc++;
   endtask

   // Reference round-robin: first valid index searching from p, modulo N.
   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] r;
      r = '0;
      if (i >= 0) r[i] = 1'b1;
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_valid = N'($urandom); req_data = $urandom; tx_busy = 1'($urandom);
         z_valid = N'($urandom); z_data = $urandom; z_busy = 1'($urandom);
         #2;
         checks++;
         if ({req_ready, grant, tx_data, tx_start, timeout_err, active,
              z_ready, z_grant, z_tx_data, z_start, z_err, z_active} !== '0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d got %h/%h/%h/%b%b%b want all zero",
                     cyc, req_ready, grant, tx_data, tx_start, timeout_err, active);
         end
         tick();
      end
      req_valid = '0; tx_busy = 1'b0; z_valid = '0; z_busy = 1'b0;
      rst = 1'b0;
      tick();
      checks++;
      if (active !== 1'b0 || req_ready !== '0 || grant !== '0 || z_active !== 1'b0) begin
         errors++;
         $display("FAIL reset_release active=%b ready=%b grant=%b want 0/0000/0000", active, req_ready, grant);
      end
      model_ptr = 0;
   endtask

   task automatic test_single();
      bit bad;
      req_data = $urandom;
      req_data[2*DW +: DW] = 8'hA5;
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL single_ready got %b want 0100", req_ready);
      end
      tick();
      req_valid = '0;
      checks++;
      if (tx_start !== 1'b1 || tx_data !== 8'hA5 || grant !== 4'b0100) begin
         errors++;
         $display("FAIL single_start start=%b data=%h grant=%b want 1/a5/0100", tx_start, tx_data, grant);
      end
      bad = 0;
      tx_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tx_start !== 1'b0 || active !== 1'b1 || tx_data !== 8'hA5) bad = 1;
      end
      tx_busy = 1'b0;
      for (int i = 1; i <= GAP; i++) begin
         tick();
         if (active !== 1'b1 || grant !== 4'b0100) bad = 1;
      end
      checks++;
      if (bad) begin
         errors++; $display("FAIL single_hold frame not held through busy and gap (active=%b grant=%b)", active, grant);
      end
      tick();
      checks++;
      if (active !== 1'b0 || grant !== '0) begin
         errors++; $display("FAIL single_idle active=%b grant=%b want 0/0000", active, grant);
      end
      model_ptr = 3;
   endtask

   task automatic test_fairness();
      int seq [5];
      logic [DW-1:0] b;
      seq = '{0, 1, 2, 3, 0};
      rst = 1'b1; tick(); rst = 1'b0; model_ptr = 0;
      req_data = $urandom;
      req_valid = '1;
      for (int f = 0; f < 5; f++) begin
         #1;
         b = req_data[seq[f]*DW +: DW];
         checks++;
         if (req_ready !== onehot(seq[f])) begin
            errors++; $display("FAIL fair_ready frame=%0d got %b want %b", f, req_ready, onehot(seq[f]));
         end
         tick();
         if (f == 4) req_valid = '0;
         checks++;
         if (grant !== onehot(seq[f]) || tx_data !== b || tx_start !== 1'b1) begin
            errors++; $display("FAIL fair_grant frame=%0d grant=%b data=%h want %b/%h", f, grant, tx_data, onehot(seq[f]), b);
         end
         model_ptr = (seq[f] + 1) % N;
         tx_busy = 1'b1;
         repeat (3) tick();
         tx_busy = 1'b0;
         repeat (GAP + 1) tick();
      end
   endtask

   task automatic test_timeout();
      int w;
      bit early;
      req_valid = '1; req_data = $urandom; tx_busy = 1'b0;
      #1;
      w = rr_pick(req_valid, model_ptr);
      checks++;
      if (req_ready !== onehot(w)) begin
         errors++; $display("FAIL to_ready got %b want %b", req_ready, onehot(w));
      end
      tick();
      model_ptr = (w + 1) % N;
      checks++;
      if (tx_start !== 1'b1) begin
         errors++; $display("FAIL to_start got %b want 1", tx_start);
      end
      early = 0;
      for (int i = 1; i < BT; i++) begin
         tick();
         if (timeout_err !== 1'b0 || active !== 1'b1) early = 1;
      end
      checks++;
      if (early) begin
         errors++; $display("FAIL to_early timeout_err or idle seen before %0d cycles", BT);
      end
      tick();
      checks++;
      if (timeout_err !== 1'b1 || active !== 1'b1) begin
         errors++; $display("FAIL to_pulse err=%b active=%b want 1/1 at start+%0d", timeout_err, active, BT);
      end
      early = 0;
      for (int i = 1; i < GAP; i++) begin
         tick();
         if (timeout_err !== 1'b0 || active !== 1'b1 || req_ready !== '0) early = 1;
      end
      checks++;
      if (early) begin
         errors++; $display("FAIL to_gap err=%b active=%b ready=%b want 0/1/0000", timeout_err, active, req_ready);
      end
      tick();
      w = rr_pick(req_valid, model_ptr);
      checks++;
      if (active !== 1'b0 || req_ready !== onehot(w)) begin
         errors++; $display("FAIL to_next active=%b ready=%b want 0/%b", active, req_ready, onehot(w));
      end
      tick();
      req_valid = '0;
      model_ptr = (w + 1) % N;
      checks++;
      if (tx_start !== 1'b1 || grant !== onehot(w) || timeout_err !== 1'b0) begin
         errors++; $display("FAIL to_served start=%b grant=%b want 1/%b", tx_start, grant, onehot(w));
      end
      tx_busy = 1'b1;
      repeat (3) tick();
      tx_busy = 1'b0;
      repeat (GAP + 1) tick();
   endtask

   task automatic test_abort();
      // Requester 1 is chosen so a surviving ptr (2) would pick a different winner than 0.
      req_valid = 4'b0010; req_data = $urandom;
      #1;
      tick();
      req_valid = '0;
      tx_busy = 1'b1;
      tick();
      tick();
      req_valid = '1;
      rst = 1'b1;
      #1;
      checks++;
      if ({active, grant, tx_start, tx_data, req_ready} !== '0) begin
         errors++;
         $display("FAIL abort_now active=%b grant=%b start=%b data=%h ready=%b want all zero",
                  active, grant, tx_start, tx_data, req_ready);
      end
      tick();
      checks++;
      if (tx_start !== 1'b0 || active !== 1'b0) begin
         errors++; $display("FAIL abort_hold start=%b active=%b want 0/0", tx_start, active);
      end
      rst = 1'b0; tx_busy = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL abort_ptr ready=%b want 0001", req_ready);
      end
      req_valid = '0;
      tick();
      checks++;
      if (tx_start !== 1'b0 || active !== 1'b0) begin
         errors++; $display("FAIL abort_replay start=%b active=%b want 0/0", tx_start, active);
      end
      model_ptr = 0;
   endtask

   task automatic test_wrap();
      z_data = $urandom;
      z_valid = 4'b1000;
      #1;
      checks++;
      if (z_ready !== 4'b1000) begin
         errors++; $display("FAIL wrap_ready3 got %b want 1000", z_ready);
      end
      tick();
      z_valid = 4'b0001;
      checks++;
      if (z_start !== 1'b1 || z_grant !== 4'b1000 || z_tx_data !== z_data[3*DW +: DW]) begin
         errors++; $display("FAIL wrap_start3 start=%b grant=%b data=%h", z_start, z_grant, z_tx_data);
      end
      z_busy = 1'b1;
      repeat (4) tick();
      z_busy = 1'b0;
      #1;
      checks++;
      if (z_ready !== '0 || z_active !== 1'b1) begin
         errors++; $display("FAIL wrap_busy ready=%b active=%b want 0000/1", z_ready, z_active);
      end
      tick();
      checks++;
      if (z_active !== 1'b0 || z_ready !== 4'b0001) begin
         errors++; $display("FAIL wrap_accept0 active=%b ready=%b want 0/0001", z_active, z_ready);
      end
      tick();
      z_valid = '0;
      checks++;
      if (z_start !== 1'b1 || z_grant !== 4'b0001 || z_tx_data !== z_data[DW-1:0]) begin
         errors++; $display("FAIL wrap_start0 start=%b grant=%b data=%h", z_start, z_grant, z_tx_data);
      end
      z_busy = 1'b1;
      repeat (2) tick();
      z_busy = 1'b0;
      tick();
      z_valid = 4'b0011;
      #1;
      checks++;
      if (z_active !== 1'b0 || z_ready !== 4'b0010) begin
         errors++; $display("FAIL wrap_ptr1 active=%b ready=%b want 0/0010", z_active, z_ready);
      end
      z_valid = '0;
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0]  v, oh;
      logic [DW-1:0] b;
      int w, d, len;
      bit bad;
      for (int f = 0; f < 24; f++) begin
         v = N'($urandom_range(1, (1 << N) - 1));
         req_data = $urandom;
         req_valid = v;
         #1;
         w = rr_pick(v, model_ptr);
         oh = onehot(w);
         b = req_data[w*DW +: DW];
         checks++;
         if (req_ready !== oh) begin
            errors++; $display("FAIL rand_ready frame=%0d valid=%b ptr=%0d got %b want %b", f, v, model_ptr, req_ready, oh);
         end
         tick();
         req_valid = N'($urandom);
         req_data = $urandom;
         checks++;
         if (tx_start !== 1'b1 || grant !== oh || tx_data !== b) begin
            errors++; $display("FAIL rand_start frame=%0d start=%b grant=%b data=%h want 1/%b/%h", f, tx_start, grant, tx_data, oh, b);
         end
         model_ptr = (w + 1) % N;
         d = $urandom_range(0, 4);
         len = $urandom_range(1, 8);
         bad = 0;
         for (int i = 0; i < d + len; i++) begin
            tx_busy = (i >= d);
            tick();
            if (grant !== oh || tx_data !== b || tx_start !== 1'b0 || timeout_err !== 1'b0 ||
                req_ready !== '0 || active !== 1'b1) bad = 1;
         end
         tx_busy = 1'b0;
         req_valid = '0;
         for (int i = 0; i < GAP; i++) begin
            tick();
            if (active !== 1'b1 || grant !== oh || tx_data !== b) bad = 1;
         end
         checks++;
         if (bad) begin
            errors++; $display("FAIL rand_hold frame=%0d d=%0d len=%0d grant=%b data=%h want %b/%h", f, d, len, grant, tx_data, oh, b);
         end
         tick();
         checks++;
         if (active !== 1'b0 || grant !== '0) begin
            errors++; $display("FAIL rand_idle frame=%0d active=%b grant=%b want 0/0000", f, active, grant);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_abort();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
